// File: rtl/tile_pixel_fetch.sv
// Tile-map display fetch: 640x480 raster timing, tile map read, pattern RAM, palette, aligned video out.
// Optional TILE_GRID_EN overlays 12'hFFF on the first column/row of every tile.
module tile_pixel_fetch #(
    parameter int    H_ACTIVE = 640,
    parameter int    H_FP     = 16,
    parameter int    H_SYNC   = 96,
    parameter int    H_BP     = 48,
    parameter int    V_ACTIVE = 480,
    parameter int    V_FP     = 10,
    parameter int    V_SYNC   = 2,
    parameter int    V_BP     = 33,
    parameter string PAT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [6:0]  map_x,
    output logic [5:0]  map_y,
    output logic        map_r,
    input  logic [5:0]  map_tile,
    input  logic        pat_we,
    input  logic [11:0] pat_addr,
    input  logic [3:0]  pat_data,
    input  logic        pal_we,
    input  logic [3:0]  pal_addr,
    input  logic [11:0] pal_data,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] rgb,
    output logic        frame_start
);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // S0 raster counters
    logic [9:0] hcount, vcount;
    logic       active, hs_raw, vs_raw, wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_en) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
            end else begin
                hcount <= hcount + 10'd1;
            end
        end
    end

    always_comb begin
        active = (hcount < H_ACT) && (vcount < V_ACT);
        hs_raw = !((hcount >= HS_BEG) && (hcount <= HS_END));
        vs_raw = !((vcount >= VS_BEG) && (vcount <= VS_END));
        wrap   = (hcount == H_LAST) && (vcount == V_LAST);
    end

    // Read strobe is gated by rst so the port is quiet while held in reset.
    assign map_x       = hcount[9:3];
    assign map_y       = vcount[8:3];
    assign map_r       = pix_en & active & ~rst;
    assign frame_start = pix_en & wrap & ~rst;

    // Pipeline control/timing stages
    logic [2:0]  px1, py1;
    logic        act1, hs1, vs1;
    logic        act2, hs2, vs2;
    logic        act3, hs3, vs3;
    logic [3:0]  pat_q;
    logic [11:0] pal_q;
`ifdef TILE_GRID_EN
    logic        grid1, grid2, grid3;
`endif

    // Pattern RAM: 64 tiles x 8x8 pixels x 4-bit colour index, not reset
    logic [3:0] pat_mem [0:4095];

    always_ff @(posedge clk) begin
        if (pat_we)
            pat_mem[pat_addr] <= pat_data;
        if (pix_en)
            pat_q <= pat_mem[{map_tile, py1, px1}];
    end

    // Palette: 16 x 12-bit, resets to a grey ramp
    logic [11:0] pal [0:15];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++)
                pal[i] <= {3{4'(i)}};
        end else if (pal_we) begin
            pal[pal_addr] <= pal_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px1   <= '0;
            py1   <= '0;
            act1  <= 1'b0;
            hs1   <= 1'b1;
            vs1   <= 1'b1;
            act2  <= 1'b0;
            hs2   <= 1'b1;
            vs2   <= 1'b1;
            act3  <= 1'b0;
            hs3   <= 1'b1;
            vs3   <= 1'b1;
            pal_q <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            de    <= 1'b0;
            rgb   <= '0;
`ifdef TILE_GRID_EN
            grid1 <= 1'b0;
            grid2 <= 1'b0;
            grid3 <= 1'b0;
`endif
        end else if (pix_en) begin
            // S1
            px1   <= hcount[2:0];
            py1   <= vcount[2:0];
            act1  <= active;
            hs1   <= hs_raw;
            vs1   <= vs_raw;
            // S2 (pattern read happens in the RAM block)
            act2  <= act1;
            hs2   <= hs1;
            vs2   <= vs1;
            // S3
            pal_q <= pal[pat_q];
            act3  <= act2;
            hs3   <= hs2;
            vs3   <= vs2;
            // S4
            hsync <= hs3;
            vsync <= vs3;
            de    <= act3;
`ifdef TILE_GRID_EN
            // Grid flag is computed early and carried so S4 only selects.
            grid1 <= (hcount[2:0] == 3'd0) || (vcount[2:0] == 3'd0);
            grid2 <= grid1;
            grid3 <= grid2;
            rgb   <= act3 ? (grid3 ? 12'hFFF : pal_q) : '0;
`else
            rgb   <= act3 ? pal_q : '0;
`endif
        end
    end

endmodule

// File: tb/tb_tile_pixel_fetch.sv
// Self-checking bench for tile_pixel_fetch on a reduced raster, with a behavioural pixel model.
module tb_tile_pixel_fetch;

    localparam int HA = 32, HF = 4, HS = 8, HB = 4;
    localparam int VA = 24, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst, pix_en, pat_we, pal_we;
    logic [5:0]  map_tile;
    logic [11:0] pat_addr;
    logic [3:0]  pat_data, pal_addr;
    logic [11:0] pal_data;
    logic [6:0]  map_x;
    logic [5:0]  map_y;
    logic        map_r, hsync, vsync, de, frame_start;
    logic [11:0] rgb;

    always #5 clk = ~clk;

    tile_pixel_fetch #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .map_x(map_x), .map_y(map_y), .map_r(map_r), .map_tile(map_tile),
        .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start)
    );

    logic [3:0]  pat_m [0:4095];
    logic [11:0] pal_m [0:15];
    logic [5:0]  tmap  [0:8191];
    int checks = 0;
    int errors = 0;
    int n = 0;
    int gap = 0;
    int fs_seen = 0;

    typedef struct {
        int   h;
        int   v;
        logic de;
        logic hs;
        logic vs;
    } tvec_t;
    tvec_t tv [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, n);
        end
    endtask

    // Expected {hsync, vsync, de, rgb} for raster position index p
    function automatic logic [14:0] model_out(input int p);
        int h, v;
        logic d, hs, vs;
        logic [11:0] c;
        logic [5:0] t;
        h  = p % HT;
        v  = (p / HT) % VT;
        d  = (h < HA) && (v < VA);
        hs = !(h >= HA + HF && h < HA + HF + HS);
        vs = !(v >= VA + VF && v < VA + VF + VS);
        c  = 12'h000;
        if (d) begin
            t = tmap[(v / 8) * 128 + h / 8];
            c = pal_m[pat_m[int'(t) * 64 + (v % 8) * 8 + h % 8]];
`ifdef TILE_GRID_EN
            if (h % 8 == 0 || v % 8 == 0) c = 12'hFFF;
`endif
        end
        return {hs, vs, d, c};
    endfunction

    function automatic logic [14:0] exp_now();
        if (n < 4) return {1'b1, 1'b1, 1'b0, 12'h000};
        return model_out(n - 4);
    endfunction

    // Expected {map_r, map_x, map_y, frame_start} with pix_en high
    function automatic logic [14:0] map_exp(input int k);
        int p, h, v;
        p = k % FRAME;
        h = p % HT;
        v = p / HT;
        return {(h < HA) && (v < VA), 7'(h / 8), 6'(v / 8), p == FRAME - 1};
    endfunction

    task automatic tick(input bit chk);
        logic       sr;
        logic [6:0] sx;
        logic [5:0] sy;
        for (int i = 0; i < gap; i++) begin
            pix_en = 1'b0;
            #2;
            check("idle_strobes", {map_r, frame_start}, 2'b00);
            @(posedge clk); #1;
            if (chk) check("idle_hold", {hsync, vsync, de, rgb}, exp_now());
        end
        pix_en = 1'b1;
        #2;
        if (chk) check("map_port", {map_r, map_x, map_y, frame_start}, map_exp(n));
        if (frame_start) fs_seen++;
        sr = map_r;
        sx = map_x;
        sy = map_y;
        @(posedge clk); #1;
        if (sr) map_tile = tmap[int'(sy) * 128 + int'(sx)];
        n++;
        if (chk) check("video", {hsync, vsync, de, rgb}, exp_now());
    endtask

    task automatic reset_model();
        n = 0;
        map_tile = '0;
        for (int i = 0; i < 16; i++) pal_m[i] = {3{4'(i)}};
    endtask

    task automatic do_reset();
        pix_en = 1'b1;
        rst = 1'b1;
        #2;
        check("reset_values", {hsync, vsync, de, rgb, frame_start, map_r}, {1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        pix_en = 1'b0;
        reset_model();
    endtask

    task automatic wr_pat(input logic [11:0] a, input logic [3:0] d);
        pat_we = 1'b1; pat_addr = a; pat_data = d; pat_m[a] = d;
        @(posedge clk); #1;
        pat_we = 1'b0;
    endtask

    task automatic wr_pal(input logic [3:0] a, input logic [11:0] d);
        pal_we = 1'b1; pal_addr = a; pal_data = d; pal_m[a] = d;
        @(posedge clk); #1;
        pal_we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{0, 0, 1, 1, 1};   tv[1]  = '{31, 0, 1, 1, 1};  tv[2]  = '{32, 0, 0, 1, 1};
        tv[3]  = '{35, 0, 0, 1, 1};  tv[4]  = '{36, 0, 0, 0, 1};  tv[5]  = '{43, 0, 0, 0, 1};
        tv[6]  = '{44, 0, 0, 1, 1};  tv[7]  = '{47, 0, 0, 1, 1};  tv[8]  = '{0, 23, 1, 1, 1};
        tv[9]  = '{31, 23, 1, 1, 1}; tv[10] = '{0, 24, 0, 1, 1};  tv[11] = '{0, 26, 0, 1, 0};
        tv[12] = '{40, 27, 0, 0, 0}; tv[13] = '{0, 28, 0, 1, 1};  tv[14] = '{47, 29, 0, 1, 1};

        rst = 1'b1; pix_en = 1'b0; pat_we = 1'b0; pal_we = 1'b0;
        pat_addr = '0; pat_data = '0; pal_addr = '0; pal_data = '0; map_tile = '0;
        for (int i = 0; i < 4096; i++) pat_m[i] = 4'h0;
        for (int i = 0; i < 8192; i++) tmap[i] = 6'd5;
        @(posedge clk); #1;

        // Directed: tile 5 solid colour 3 except (1,1)=7, palette[3]=F00
        do_reset();
        for (int i = 0; i < 64; i++) wr_pat({6'd5, 6'(i)}, 4'd3);
        wr_pat({6'd5, 3'd1, 3'd1}, 4'd7);
        wr_pal(4'd3, 12'hF00);
        for (int i = 0; i < 4; i++) tick(1);
`ifdef TILE_GRID_EN
        check("first_pixel", {de, rgb}, {1'b1, 12'hFFF});
`else
        check("first_pixel", {de, rgb}, {1'b1, 12'hF00});
`endif
        while (n < 52) tick(1);
        pal_we = 1'b1; pal_addr = 4'd3; pal_data = 12'h0F0;
        tick(1);
        pal_we = 1'b0;
        check("grey_ramp_entry7", rgb, 12'h777);
        tick(0);
        check("pal_read_write_same_clk", rgb, 12'hF00);
        pal_m[3] = 12'h0F0;
        for (int i = 0; i < 8; i++) tick(1);

        // Random contents, continuous pix_en, timing table within first frame
        for (int i = 0; i < 4096; i++) wr_pat(12'(i), 4'($urandom_range(0, 15)));
        for (int i = 0; i < 8192; i++) tmap[i] = 6'($urandom);
        do_reset();
        for (int i = 0; i < 16; i++) wr_pal(4'(i), 12'($urandom));
        fs_seen = 0;
        for (int i = 0; i < 15; i++) begin
            while (n - 4 < tv[i].v * HT + tv[i].h) tick(1);
            check("timing_table", {hsync, vsync, de}, {tv[i].hs, tv[i].vs, tv[i].de});
        end
        while (n < 2 * FRAME + 8) tick(1);
        check("frame_start_count", fs_seen, 2);

        // pix_en one in four
        do_reset();
        for (int i = 0; i < 16; i++) wr_pal(4'(i), 12'($urandom));
        gap = 3;
        while (n < FRAME + 20) tick(1);
        gap = 0;

        // Asynchronous reset mid-line at (20,10)
        do_reset();
        while (n < 10 * HT + 20) tick(1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_mid_line", {hsync, vsync, de, rgb, map_r, frame_start},
              {1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0});
        @(posedge clk); #1;
        rst = 1'b0;
        pix_en = 1'b0;
        reset_model();
        while (n < 2 * HT + 10) tick(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
